strobe_rate_meter: RTL
======================

Name: strobe_rate_meter

Overview:
- Consumes the single-cycle strobe produced by the clock-domain-crossing pulse stage, already in the slow domain.
- Counts strobe rising edges over a programmable window of clock cycles.
- Publishes each window's count with a one-cycle valid flag and an overflow flag.
- Used for event-rate monitoring downstream of the CDC stage.

Parameters:
- WINDOW_W, 16, width of window length input and internal window counter
- COUNT_W, 8, width of count output and accumulator
- MIN_GAP, 3, minimum edge-to-edge spacing in cycles; used only with the optional gap check

Ports:
- clk_in  input  1  single clock (slow domain)
- rst_n_in  input  1  asynchronous active-low reset
- strobe_in  input  1  synchronized strobe from the CDC pulse stage; may be held high for more than one cycle
- enable_in  input  1  level; high = measure continuously
- window_len_in  input  WINDOW_W  window length in cycles; sampled at each window start
- count_out  output  COUNT_W  edge count of the last completed window
- count_valid_out  output  1  one-cycle pulse when count_out is updated
- overflow_out  output  1  accumulator saturated in the window just reported; valid with count_valid_out
- gap_err_out  output  1  spacing violation pulse; constant 0 unless the optional feature is compiled in

Behaviour:
- Reset: all outputs 0; accumulator 0; window counter 0; strobe_d 0; state IDLE. Asynchronous assert, synchronous release.
- Edge detect:
  - edge = strobe_in & ~strobe_d.
  - strobe_d is updated every cycle, in every state.
  - A strobe held high for N cycles counts once.
  - strobe_in high at reset release counts as an edge only if the state is RUN.
- State IDLE:
  - Accumulator held at 0.
  - If enable_in = 1 and window_len_in != 0: latch len, clear window counter, go RUN on the next edge of clk_in.
  - If window_len_in = 0: stay IDLE.
- State RUN:
  - The window is exactly len cycles; the window counter runs 0..len-1.
  - Each edge increments the accumulator, saturating at 2^COUNT_W-1; an increment attempted at saturation sets the window's overflow bit.
- Last cycle of the window (counter = len-1):
  - An edge on this cycle belongs to the closing window.
  - Registered on the next clock: count_out = final accumulator, overflow_out = window overflow bit, count_valid_out = 1 for exactly one cycle.
  - Accumulator and overflow bit are cleared.
  - If enable_in = 1 and window_len_in != 0: re-sample window_len_in and start the next window immediately, back-to-back with no dead cycle.
  - Otherwise go IDLE.
- Latency: count_valid_out asserts 1 cycle after the window's last cycle.
- enable_in deasserted mid-window:
  - Abort on that cycle: no valid pulse, accumulator and overflow cleared, go IDLE.
  - count_out and overflow_out keep their last reported values.
- count_out and overflow_out are stable between valid pulses.
- window_len_in changes mid-window: ignored until the next window start.
- Reset mid-window: window discarded, all outputs return to 0.

Optional Feature:
- Macro: STROBE_GAP_CHECK_EN.
- Defined:
  - A gap counter counts cycles since the previous edge and saturates at MIN_GAP.
  - An edge arriving with distance < MIN_GAP cycles from the previous edge pulses gap_err_out for one cycle, on the cycle after the offending edge.
  - The offending edge is still counted.
  - The gap counter runs in all states; after reset or abort, the first edge never flags.
- Undefined: gap_err_out tied to 0; no gap-counter logic.

Decomposition:
- Shared package strobe_meter_pkg:
  - state enum (IDLE, RUN)
  - default constants for WINDOW_W, COUNT_W, MIN_GAP
- One sub-module, strobe_edge_det:
  - strobe_d register plus edge output.
  - Reusable by other consumers of the CDC pulse stage.
- Window/accumulator logic stays in the top module.

Test Plan:
- Reset and idle: hold rst_n_in = 0 for 3 cycles, then enable_in = 0 with strobes -> all outputs 0, no valid pulse.
- Basic window: window_len_in = 10, enable_in = 1, three single-cycle strobes at window cycles 1, 4, 7 -> count_valid_out 1 cycle after window cycle 9, count_out = 3, overflow_out = 0.
- Level and boundary handling: strobe held high for 4 cycles, plus a separate edge on window cycle len-1 -> held strobe counts once, boundary edge is counted in the closing window, next window starts at 0.
- Saturation: COUNT_W = 4, window_len_in = 40, 20 edges spaced 2 cycles apart -> count_out = 15, overflow_out = 1; the following window with 2 edges reports 2 with overflow_out = 0.
- Abort and relength: deassert enable_in at window cycle 5 -> no valid pulse, count_out holds its prior value; change window_len_in from 10 to 6 mid-window -> the current window stays 10, the next window is 6.
- Gap check (macro defined, MIN_GAP = 3): edges at distances 5 then 2 -> gap_err_out pulses only after the second edge, and both edges are counted; macro undefined -> gap_err_out stays 0.

Source files
------------

// File: rtl/strobe_meter_pkg.sv
// strobe_meter_pkg
//   Shared definitions for the strobe rate meter: FSM state encoding and the
//   default widths / minimum edge spacing used by strobe_rate_meter.
package strobe_meter_pkg;

   localparam int unsigned WINDOW_W_DEF = 16;
   localparam int unsigned COUNT_W_DEF  = 8;
   localparam int unsigned MIN_GAP_DEF  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } meter_state_t;

endpackage

// File: rtl/strobe_edge_det.sv
// strobe_edge_det
//   Rising-edge detector for the synchronized strobe coming out of the CDC
//   pulse stage. A strobe held high for several cycles yields one edge.
// Ports:
//   clk_in     - slow-domain clock
//   rst_n_in   - asynchronous active-low reset
//   strobe_in  - synchronized strobe (level, may stay high for many cycles)
//   edge_out   - combinational, high on the first cycle strobe_in is high
module strobe_edge_det (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic strobe_in,
   output logic edge_out
);

   logic strobe_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) strobe_d <= 1'b0;
      else           strobe_d <= strobe_in;
   end

   assign edge_out = strobe_in & ~strobe_d;

endmodule

// File: rtl/strobe_rate_meter.sv
// strobe_rate_meter
//   Counts strobe rising edges over a programmable window of clk_in cycles and
//   publishes each window's count with a one-cycle valid and an overflow flag.
//   Optional spacing check compiled in with macro STROBE_GAP_CHECK_EN.
// Ports:
//   clk_in          - slow-domain clock
//   rst_n_in        - asynchronous active-low reset
//   strobe_in       - synchronized strobe from the CDC pulse stage
//   enable_in       - level, high = measure continuously
//   window_len_in   - window length in cycles, sampled at each window start
//   count_out       - edge count of the last completed window
//   count_valid_out - one-cycle pulse when count_out updates
//   overflow_out    - accumulator saturated in the reported window
//   gap_err_out     - edge spacing violation pulse (0 without the macro)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | not measuring; accumulator held at 0, waiting for enable + len
// RUN   | window open; win_cnt counts remaining cycles down to 0 (last)
module strobe_rate_meter
   import strobe_meter_pkg::*;
#(
   parameter int unsigned WINDOW_W = WINDOW_W_DEF,
   parameter int unsigned COUNT_W  = COUNT_W_DEF,
   parameter int unsigned MIN_GAP  = MIN_GAP_DEF
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                strobe_in,
   input  logic                enable_in,
   input  logic [WINDOW_W-1:0] window_len_in,
   output logic [COUNT_W-1:0]  count_out,
   output logic                count_valid_out,
   output logic                overflow_out,
   output logic                gap_err_out
);

   if (WINDOW_W < 1 || COUNT_W < 1 || MIN_GAP < 1) begin : g_param_chk
      $error("strobe_rate_meter: WINDOW_W, COUNT_W and MIN_GAP must be >= 1");
   end

   meter_state_t        state, state_nxt;
   logic [WINDOW_W-1:0] win_cnt, win_cnt_nxt;
   logic [COUNT_W-1:0]  acc, acc_nxt, acc_inc;
   logic                win_ovf, win_ovf_nxt, ovf_inc;
   logic [COUNT_W-1:0]  count_nxt;
   logic                ovf_out_nxt, valid_nxt;
   logic                strobe_edge;
   logic                start_ok;

   strobe_edge_det u_edge_det (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .strobe_in (strobe_in),
      .edge_out  (strobe_edge)
   );

   assign start_ok = enable_in && (window_len_in != '0);

   // Saturating increment; an edge that finds the accumulator full marks the window.
   assign acc_inc = (strobe_edge && acc != '1) ? acc + COUNT_W'(1) : acc;
   assign ovf_inc = win_ovf | (strobe_edge & (acc == '1));

   always_comb begin
      state_nxt   = state;
      win_cnt_nxt = win_cnt;
      acc_nxt     = acc;
      win_ovf_nxt = win_ovf;
      count_nxt   = count_out;
      ovf_out_nxt = overflow_out;
      valid_nxt   = 1'b0;
      case (state)
         IDLE: begin
            acc_nxt     = '0;
            win_ovf_nxt = 1'b0;
            if (start_ok) begin
               state_nxt   = RUN;
               win_cnt_nxt = window_len_in - WINDOW_W'(1);
            end
         end
         RUN: begin
            if (win_cnt == '0) begin
               // Last window cycle: an edge here still belongs to this window.
               count_nxt   = acc_inc;
               ovf_out_nxt = ovf_inc;
               valid_nxt   = 1'b1;
               acc_nxt     = '0;
               win_ovf_nxt = 1'b0;
               if (start_ok) win_cnt_nxt = window_len_in - WINDOW_W'(1);
               else          state_nxt   = IDLE;
            end else if (!enable_in) begin
               state_nxt   = IDLE;
               win_cnt_nxt = '0;
               acc_nxt     = '0;
               win_ovf_nxt = 1'b0;
            end else begin
               win_cnt_nxt = win_cnt - WINDOW_W'(1);
               acc_nxt     = acc_inc;
               win_ovf_nxt = ovf_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state           <= IDLE;
         win_cnt         <= '0;
         acc             <= '0;
         win_ovf         <= 1'b0;
         count_out       <= '0;
         overflow_out    <= 1'b0;
         count_valid_out <= 1'b0;
      end else begin
         state           <= state_nxt;
         win_cnt         <= win_cnt_nxt;
         acc             <= acc_nxt;
         win_ovf         <= win_ovf_nxt;
         count_out       <= count_nxt;
         overflow_out    <= ovf_out_nxt;
         count_valid_out <= valid_nxt;
      end
   end

`ifdef STROBE_GAP_CHECK_EN
   localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

   logic [GAP_W-1:0] gap_cnt;
   logic             gap_err_q;
   logic             abort;

   assign abort = (state == RUN) && (win_cnt != '0) && !enable_in;

   // gap_cnt = cycles since the last edge, saturating at MIN_GAP. Reset and
   // abort park it at MIN_GAP so the next edge can never be flagged.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         gap_cnt   <= GAP_W'(MIN_GAP);
         gap_err_q <= 1'b0;
      end else begin
         gap_err_q <= strobe_edge && (gap_cnt < GAP_W'(MIN_GAP));
         if (abort)                         gap_cnt <= GAP_W'(MIN_GAP);
         else if (strobe_edge)              gap_cnt <= GAP_W'(1);
         else if (gap_cnt < GAP_W'(MIN_GAP)) gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   assign gap_err_out = gap_err_q;
`else
   assign gap_err_out = 1'b0;
`endif

endmodule
